// File: rtl/seven_seg_scan_if.sv
// Bundle between the game/timer producers and the 4-digit display scanner:
// digit codes, letter/number select and decimal points in, multiplexed pins out.
interface seven_seg_scan_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       ltr_flag;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output digit0, digit1, digit2, digit3, ltr_flag, dp_in,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, ltr_flag, dp_in,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Common-anode 4-digit 7-segment scanner with once-per-frame input snapshot
// and anti-ghost blanking at the start of every digit slot.
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_scan_if.slave   disp
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0][3:0]    code_q, code_d;
    logic               ltr_q, ltr_d;
    logic [3:0]         dpsh_q, dpsh_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               tick_q, tick_d;
    logic               slot_end, snap;

    function automatic logic [6:0] decode(input logic [3:0] code, input logic ltr);
        logic [6:0] s;
        s = 7'h7F;
        if (ltr) begin
            case (code)
                4'h0: s = 7'h40;
                4'h1: s = 7'h06;
                4'h2: s = 7'h47;
                4'h3: s = 7'h0C;
                4'h4: s = 7'h2F;
                4'h5: s = 7'h09;
                4'hA: s = 7'h79;
                default: s = 7'h7F;
            endcase
        end else begin
            case (code)
                4'h0: s = 7'h40;
                4'h1: s = 7'h79;
                4'h2: s = 7'h24;
                4'h3: s = 7'h30;
                4'h4: s = 7'h19;
                4'h5: s = 7'h12;
                4'h6: s = 7'h02;
                4'h7: s = 7'h78;
                4'h8: s = 7'h00;
                4'h9: s = 7'h10;
                4'hF: s = 7'h7F;
                default: s = 7'h3F;
            endcase
        end
        return s;
    endfunction

    // Outputs are registered from next-state values so the pins track (cnt, idx) with no lag.
    always_comb begin
        slot_end = (cnt_q == LAST);
        snap     = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        code_d   = code_q;
        ltr_d    = ltr_q;
        dpsh_d   = dpsh_q;
        if (snap) begin
            code_d = {disp.digit3, disp.digit2, disp.digit1, disp.digit0};
            ltr_d  = disp.ltr_flag;
            dpsh_d = disp.dp_in;
        end
        an_d   = '1;
        seg_d  = '1;
        dp_d   = 1'b1;
        tick_d = snap;
        if (cnt_d >= BLANK) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = decode(code_d[idx_d], ltr_d);
            dp_d  = ~dpsh_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            code_q <= '1;
            ltr_q  <= 1'b0;
            dpsh_q <= '0;
            an_q   <= '1;
            seg_q  <= '1;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            code_q <= code_d;
            ltr_q  <= ltr_d;
            dpsh_q <= dpsh_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= tick_d;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a frame model pushes expected pin values
// each cycle, directed steps push hand-derived values at chosen slots.
module tb_seven_seg_scan;
    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (bus)
    );

    logic [6:0] NUM [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};
    logic [6:0] LTR [16] = '{7'h40, 7'h06, 7'h47, 7'h0C, 7'h2F, 7'h09, 7'h7F, 7'h7F,
                             7'h7F, 7'h7F, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    obs_t        exp_q[$];
    int unsigned vectors = 0;
    int unsigned fails   = 0;

    int unsigned m_cnt, m_idx;
    logic [3:0]  m_code [4];
    logic        m_ltr;
    logic [3:0]  m_dp;
    logic        m_tick;

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        for (int k = 0; k < 4; k++) m_code[k] = 4'hF;
        m_ltr  = 1'b0;
        m_dp   = 4'h0;
        m_tick = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_tick = (m_cnt == DIV - 1) && (m_idx == 3);
            if (m_tick) begin
                m_code[0] = bus.digit0;
                m_code[1] = bus.digit1;
                m_code[2] = bus.digit2;
                m_code[3] = bus.digit3;
                m_ltr     = bus.ltr_flag;
                m_dp      = bus.dp_in;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e.an   = 4'hF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.tick = m_tick;
        if (m_cnt >= BLK) begin
            e.an  = ~(4'b0001 << m_idx);
            e.seg = m_ltr ? LTR[m_code[m_idx]] : NUM[m_code[m_idx]];
            e.dp  = ~m_dp[m_idx];
        end
        return e;
    endfunction

    task automatic check(input string tag);
        obs_t e, o;
        e = exp_q.pop_front();
        o = {bus.an, bus.seg, bus.dp, bus.frame_tick};
        vectors++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed an=%h seg=%h dp=%b tick=%b, expected an=%h seg=%h dp=%b tick=%b",
                   tag, o.an, o.seg, o.dp, o.tick, e.an, e.seg, e.dp, e.tick);
        end
        vectors++;
        assert ($countones(~o.an) <= 1) else begin
            fails++;
            $error("FAIL %s_ghost: observed an=%h, expected at most one anode low", tag, o.an);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
        #1;
        check("scan");
    endtask

    task automatic expect_now(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input logic tick);
        exp_q.push_back({an, seg, dp, tick});
        check(tag);
    endtask

    task automatic goto(input int unsigned idx, input int unsigned cnt);
        int unsigned n = 0;
        while (!(m_idx == idx && m_cnt == cnt) && n < 64) begin
            cyc();
            n++;
        end
        vectors++;
        assert (m_idx == idx && m_cnt == cnt) else begin
            fails++;
            $error("FAIL goto: observed idx=%0d cnt=%0d, expected idx=%0d cnt=%0d", m_idx, m_cnt, idx, cnt);
        end
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic ltr, input logic [3:0] dpi);
        bus.digit3   = d3;
        bus.digit2   = d2;
        bus.digit1   = d1;
        bus.digit0   = d0;
        bus.ltr_flag = ltr;
        bus.dp_in    = dpi;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0);

        // reset hold, then first blank frame and the first tick 32 cycles after release
        for (int i = 0; i < 3; i++) cyc();
        expect_now("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) cyc();
        cyc();
        expect_now("t1_tick", 4'hF, 7'h7F, 1'b1, 1'b1);
        goto(0, 2); expect_now("t1_d0", 4'hE, 7'h19, 1'b1, 1'b0);
        goto(1, 2); expect_now("t1_d1", 4'hD, 7'h30, 1'b1, 1'b0);
        goto(2, 2); expect_now("t1_d2", 4'hB, 7'h24, 1'b1, 1'b0);
        goto(3, 2); expect_now("t1_d3", 4'h7, 7'h79, 1'b1, 1'b0);

        // letter table "HI"
        set_digits(4'hF, 4'hF, 4'h5, 4'hA, 1'b1, 4'h0);
        goto(0, 2); expect_now("t2_I", 4'hE, 7'h79, 1'b1, 1'b0);
        goto(1, 2); expect_now("t2_H", 4'hD, 7'h09, 1'b1, 1'b0);
        goto(2, 2); expect_now("t2_b2", 4'hB, 7'h7F, 1'b1, 1'b0);
        goto(3, 2); expect_now("t2_b3", 4'h7, 7'h7F, 1'b1, 1'b0);

        // mid-frame input change is held off until the next snapshot
        set_digits(4'h1, 4'h2, 4'h3, 4'h3, 1'b0, 4'h0);
        goto(0, 2); expect_now("t3_old", 4'hE, 7'h30, 1'b1, 1'b0);
        goto(1, 3);
        bus.digit0 = 4'h8;
        goto(3, 7); expect_now("t3_hold", 4'h7, 7'h79, 1'b1, 1'b0);
        goto(0, 2); expect_now("t3_new", 4'hE, 7'h00, 1'b1, 1'b0);

        // dash/blank codes and decimal points
        set_digits(4'hE, 4'hF, 4'hB, 4'hA, 1'b0, 4'b0101);
        goto(3, 7);
        goto(0, 2); expect_now("t5_A", 4'hE, 7'h3F, 1'b0, 1'b0);
        goto(1, 2); expect_now("t5_B", 4'hD, 7'h3F, 1'b1, 1'b0);
        goto(2, 2); expect_now("t5_F", 4'hB, 7'h7F, 1'b0, 1'b0);
        goto(3, 2); expect_now("t5_E", 4'h7, 7'h3F, 1'b1, 1'b0);
        set_digits(4'hE, 4'hF, 4'hD, 4'hC, 1'b0, 4'b0101);
        goto(0, 2); expect_now("t5_C", 4'hE, 7'h3F, 1'b0, 1'b0);
        goto(1, 2); expect_now("t5_D", 4'hD, 7'h3F, 1'b1, 1'b0);
        goto(2, 1); expect_now("t5_blank", 4'hF, 7'h7F, 1'b1, 1'b0);

        // long random soak; the model and ghost check run on every cycle
        goto(0, 0);
        for (int f = 0; f < 1000; f++) begin
            int unsigned r;
            r = $urandom_range(DIV * 4 - 1);
            for (int c = 0; c < DIV * 4; c++) begin
                if (c == r)
                    set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                               1'($urandom), 4'($urandom));
                cyc();
            end
        end

        // asynchronous reset in the middle of slot 2
        set_digits(4'h8, 4'h8, 4'h8, 4'h8, 1'b0, 4'hF);
        goto(3, 7);
        goto(2, 3);
        expect_now("t6_pre", 4'hB, 7'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_now("t6_async", 4'hF, 7'h7F, 1'b1, 1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;
        cyc();
        goto(0, 2); expect_now("t6_restart", 4'hE, 7'h7F, 1'b1, 1'b0);
        goto(1, 2); expect_now("t6_blank1", 4'hD, 7'h7F, 1'b1, 1'b0);
        goto(0, 2); expect_now("t6_frame2", 4'hE, 7'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
